memory_access_unit: RTL and testbench

- Responder for the control unit's memory request interface (`memory_operation`/`cyc`/`ack`/`done`/`data_valid`/`err`).
- Converts one instruction fetch, load or store request into a single Wishbone-classic bus transfer.
- Performs byte-lane steering, load sign/zero extension, alignment checking and a bus watchdog.
- Sits between `control_unit` and the system bus; the result returns on `fetched_data`.

---
 rtl/global_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/memory_access_unit.sv | 148 ++++++++++++++
 tb/tb_memory_access_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// Shared types for the memory access path: request opcodes, funct3 encodings
// and the memory access unit state encoding.
package global_pkg;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        FETCH_DATA = 2'd1,
        LOAD_DATA  = 2'd2,
        STORE_DATA = 2'd3
    } memory_operation_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } mau_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads and
// the alignment / illegal-encoding check. Purely combinational.
module mem_lane_align
    import global_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rd_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_illegal
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rd_data >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_rd_data[31:16] : i_rd_data[15:0];

    // Byte enables and lane-replicated write data from the access size
    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_sel   = 4'b0001 << i_offset;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_sel   = 4'b0011 << i_offset;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load value extraction with sign or zero extension
    always_comb begin
        o_load = i_rd_data;
        case (i_funct3)
            LB:      o_load = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load = {24'd0, w_byte};
            LH:      o_load = {{16{w_half[15]}}, w_half};
            LHU:     o_load = {16'd0, w_half};
            default: ;
        endcase
    end

    // Misaligned halfword/word or an encoding with no meaning for the op
    always_comb begin
        o_illegal = 1'b0;
        if (i_funct3[1:0] == 2'b01 && i_offset[0])
            o_illegal = 1'b1;
        if (i_funct3[1:0] == 2'b10 && i_offset != 2'b00)
            o_illegal = 1'b1;
        if (i_is_store && i_funct3 > SW)
            o_illegal = 1'b1;
        if (!i_is_store && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111))
            o_illegal = 1'b1;
    end

endmodule

// File: rtl/memory_access_unit.sv
// Turns one fetch/load/store request from the control unit into a single
// Wishbone-classic transfer, with alignment checking and a bus watchdog.
module memory_access_unit
    import global_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  memory_operation_t memory_operation,
    input  logic              cyc,
    input  logic [2:0]        funct3,
    input  logic [31:0]       pc,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              ack,
    output logic              err,
    output logic              done,
    output logic              data_valid,
    output logic [31:0]       fetched_data,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal
    localparam int WD_W = (TO_W > 0) ? TO_W : 1;

    mau_state_t        r_state;
    memory_operation_t r_op;
    logic [2:0]        r_f3;
    logic [31:0]       r_addr;
    logic [31:0]       r_sd;
    logic [WD_W-1:0]   r_wd;
    logic              r_ack, r_err, r_done, r_dv;
    logic [31:0]       r_fd;

    logic              w_idle, w_bus, w_req, w_is_store, w_illegal, w_timeout;
    logic [2:0]        w_f3_in, w_f3;
    logic [31:0]       w_addr_in, w_addr, w_sd;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata, w_load;

    assign w_idle    = (r_state == IDLE);
    assign w_bus     = (r_state == BUS);
    assign w_req     = cyc && (memory_operation != MEM_NONE);
    assign w_f3_in   = (memory_operation == FETCH_DATA) ? LW : funct3;
    assign w_addr_in = (memory_operation == FETCH_DATA) ? pc : addr;

    // The aligner checks the incoming request while idle, and steers the
    // latched request for the rest of the transaction.
    assign w_f3       = w_idle ? w_f3_in   : r_f3;
    assign w_addr     = w_idle ? w_addr_in : r_addr;
    assign w_sd       = w_idle ? store_data : r_sd;
    assign w_is_store = w_idle ? (memory_operation == STORE_DATA) : (r_op == STORE_DATA);
    assign w_timeout  = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT));

    mem_lane_align u_align (
        .i_funct3     (w_f3),
        .i_is_store   (w_is_store),
        .i_offset     (w_addr[1:0]),
        .i_store_data (w_sd),
        .i_rd_data    (wb_dat_i),
        .o_sel        (w_sel),
        .o_wdata      (w_wdata),
        .o_load       (w_load),
        .o_illegal    (w_illegal)
    );

    assign ack          = r_ack;
    assign err          = r_err;
    assign done         = r_done;
    assign data_valid   = r_dv;
    assign fetched_data = r_fd;
    assign wb_cyc_o     = w_bus;
    assign wb_stb_o     = w_bus;
    assign wb_we_o      = w_bus && (r_op == STORE_DATA);
    assign wb_sel_o     = w_bus ? w_sel : 4'b0000;
    assign wb_dat_o     = w_bus ? w_wdata : 32'd0;
    assign wb_adr_o     = {r_addr[31:2], 2'b00};

    // Request/transfer/response sequencing with registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= MEM_NONE;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_sd    <= 32'd0;
            r_wd    <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_dv    <= 1'b0;
            r_fd    <= 32'd0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_dv   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_ack   <= 1'b1;
                        r_op    <= memory_operation;
                        r_f3    <= w_f3_in;
                        r_addr  <= w_addr_in;
                        r_sd    <= store_data;
                        r_wd    <= '0;
                        r_state <= w_illegal ? FAULT : BUS;
                    end
                end
                BUS: begin
                    if (wb_err_i) begin
                        r_state <= FAULT;
                    end else if (wb_ack_i) begin
                        if (r_op != STORE_DATA)
                            r_fd <= w_load;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_state <= FAULT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                RESP: begin
                    r_done  <= 1'b1;
                    r_dv    <= (r_op != STORE_DATA);
                    r_state <= IDLE;
                end
                FAULT: begin
                    r_err   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed table-driven bench for memory_access_unit plus hand sequences
// for watchdog timeout, bus error and reset during a transfer.
module tb_memory_access_unit;
    import global_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    memory_operation_t memory_operation = MEM_NONE;
    logic              cyc = 1'b0;
    logic [2:0]        funct3 = 3'd0;
    logic [31:0]       pc = 32'd0, addr = 32'd0, store_data = 32'd0;
    logic              ack, err, done, data_valid;
    logic [31:0]       fetched_data, wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    logic              slv_ack_en = 1'b1;
    logic              slv_err_en = 1'b0;
    logic [31:0]       slv_data = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // Zero-wait slave: responds in the same cycle the strobe is seen
    assign wb_ack_i = wb_cyc_o & wb_stb_o & slv_ack_en;
    assign wb_err_i = wb_cyc_o & wb_stb_o & slv_err_en;
    assign wb_dat_i = slv_data;

    always #5 clk = ~clk;

    memory_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .memory_operation(memory_operation), .cyc(cyc),
        .funct3(funct3), .pc(pc), .addr(addr), .store_data(store_data),
        .ack(ack), .err(err), .done(done), .data_valid(data_valid),
        .fetched_data(fetched_data), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    typedef struct {
        string             name;
        memory_operation_t op;
        logic [2:0]        f3;
        logic [31:0]       pc;
        logic [31:0]       addr;
        logic [31:0]       sd;
        logic [31:0]       rdata;
        logic              exp_fault;
        logic [3:0]        exp_sel;
        logic [31:0]       exp_dato;
        logic [31:0]       exp_adr;
        logic [31:0]       exp_fd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one request and follow it until done (bounded)
    task automatic do_req(input memory_operation_t op, input logic [2:0] f3,
                          input logic [31:0] p, input logic [31:0] a, input logic [31:0] sd,
                          output logic got_ack, output int cyc_cycles, output logic got_done,
                          output logic got_err, output logic got_dv, output logic [3:0] sel,
                          output logic [31:0] dato, output logic we, output logic [31:0] adr);
        @(negedge clk);
        memory_operation = op; funct3 = f3; pc = p; addr = a; store_data = sd; cyc = 1'b1;
        @(negedge clk);
        got_ack = ack;
        cyc = 1'b0; memory_operation = MEM_NONE;
        cyc_cycles = 0; got_done = 1'b0; got_err = 1'b0; got_dv = 1'b0;
        sel = 4'h0; dato = 32'd0; we = 1'b0; adr = 32'd0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (wb_cyc_o) begin
                cyc_cycles++;
                sel = wb_sel_o; dato = wb_dat_o; we = wb_we_o; adr = wb_adr_o;
            end
            if (done) begin
                got_done = 1'b1; got_err = err; got_dv = data_valid;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic        g_ack, g_done, g_err, g_dv, g_we;
        int          g_cyc;
        logic [3:0]  g_sel;
        logic [31:0] g_dato, g_adr;
        bit          is_st;

        vecs[0]  = '{"fetch4",    FETCH_DATA, 3'd0, 32'h4, 32'h0,   32'h0,        32'h0000_0093, 1'b0, 4'hF, 32'h0,         32'h4,   32'h0000_0093};
        vecs[1]  = '{"lb103",     LOAD_DATA,  LB,   32'h0, 32'h103, 32'h0,        32'h80AA_BBCC, 1'b0, 4'h8, 32'h0,         32'h100, 32'hFFFF_FF80};
        vecs[2]  = '{"lbu103",    LOAD_DATA,  LBU,  32'h0, 32'h103, 32'h0,        32'h80AA_BBCC, 1'b0, 4'h8, 32'h0,         32'h100, 32'h0000_0080};
        vecs[3]  = '{"sh102",     STORE_DATA, SH,   32'h0, 32'h102, 32'h1234_5678, 32'h0,        1'b0, 4'hC, 32'h5678_5678, 32'h100, 32'h0000_0080};
        vecs[4]  = '{"lw101",     LOAD_DATA,  LW,   32'h0, 32'h101, 32'h0,        32'h1111_1111, 1'b1, 4'h0, 32'h0,         32'h0,   32'h0000_0080};
        vecs[5]  = '{"lh102",     LOAD_DATA,  LH,   32'h0, 32'h102, 32'h0,        32'h80AA_BBCC, 1'b0, 4'hC, 32'h0,         32'h100, 32'hFFFF_80AA};
        vecs[6]  = '{"lhu100",    LOAD_DATA,  LHU,  32'h0, 32'h100, 32'h0,        32'h80AA_BBCC, 1'b0, 4'h3, 32'h0,         32'h100, 32'h0000_BBCC};
        vecs[7]  = '{"sb101",     STORE_DATA, SB,   32'h0, 32'h101, 32'h0000_00A5, 32'h0,        1'b0, 4'h2, 32'hA5A5_A5A5, 32'h100, 32'h0000_BBCC};
        vecs[8]  = '{"sw200",     STORE_DATA, SW,   32'h0, 32'h200, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'hF, 32'hDEAD_BEEF, 32'h200, 32'h0000_BBCC};
        vecs[9]  = '{"ld_f3_011", LOAD_DATA,  3'b011, 32'h0, 32'h0, 32'h0,        32'h2222_2222, 1'b1, 4'h0, 32'h0,         32'h0,   32'h0000_BBCC};
        vecs[10] = '{"st_f3_100", STORE_DATA, 3'b100, 32'h0, 32'h0, 32'h0,        32'h0,         1'b1, 4'h0, 32'h0,         32'h0,   32'h0000_BBCC};
        vecs[11] = '{"lh101",     LOAD_DATA,  LH,   32'h0, 32'h101, 32'h0,        32'h3333_3333, 1'b1, 4'h0, 32'h0,         32'h0,   32'h0000_BBCC};
        vecs[12] = '{"lb001",     LOAD_DATA,  LB,   32'h0, 32'h001, 32'h0,        32'h0000_7F00, 1'b0, 4'h2, 32'h0,         32'h0,   32'h0000_007F};
        vecs[13] = '{"fetch8_f3", FETCH_DATA, LH,   32'h8, 32'h3,   32'h0,        32'h00A0_0113, 1'b0, 4'hF, 32'h0,         32'h8,   32'h00A0_0113};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'd0);
        chk("rst_fd", fetched_data, 32'd0);
        rst = 1'b0;

        // cyc with MEM_NONE must be ignored
        @(negedge clk);
        cyc = 1'b1; memory_operation = MEM_NONE;
        @(negedge clk);
        chk("none_ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        chk("none_cyc", {31'd0, wb_cyc_o}, 32'd0);
        cyc = 1'b0;

        foreach (vecs[k]) begin
            slv_data = vecs[k].rdata;
            is_st = (vecs[k].op == STORE_DATA);
            do_req(vecs[k].op, vecs[k].f3, vecs[k].pc, vecs[k].addr, vecs[k].sd,
                   g_ack, g_cyc, g_done, g_err, g_dv, g_sel, g_dato, g_we, g_adr);
            chk({vecs[k].name, "_ack"}, {31'd0, g_ack}, 32'd1);
            chk({vecs[k].name, "_done"}, {31'd0, g_done}, 32'd1);
            chk({vecs[k].name, "_err"}, {31'd0, g_err}, {31'd0, vecs[k].exp_fault});
            chk({vecs[k].name, "_dv"}, {31'd0, g_dv}, {31'd0, !vecs[k].exp_fault && !is_st});
            chk({vecs[k].name, "_cyccnt"}, g_cyc, vecs[k].exp_fault ? 32'd0 : 32'd1);
            chk({vecs[k].name, "_fd"}, fetched_data, vecs[k].exp_fd);
            if (!vecs[k].exp_fault) begin
                chk({vecs[k].name, "_sel"}, {28'd0, g_sel}, {28'd0, vecs[k].exp_sel});
                chk({vecs[k].name, "_adr"}, g_adr, vecs[k].exp_adr);
                chk({vecs[k].name, "_we"}, {31'd0, g_we}, {31'd0, is_st});
                if (is_st)
                    chk({vecs[k].name, "_dato"}, g_dato, vecs[k].exp_dato);
            end
        end

        // Watchdog: slave never answers, bus held TIMEOUT+1 cycles then err
        slv_ack_en = 1'b0;
        do_req(LOAD_DATA, LW, 32'h0, 32'h40, 32'h0, g_ack, g_cyc, g_done, g_err, g_dv, g_sel, g_dato, g_we, g_adr);
        chk("to_cyccnt", g_cyc, 32'd5);
        chk("to_done", {31'd0, g_done}, 32'd1);
        chk("to_err", {31'd0, g_err}, 32'd1);
        chk("to_dv", {31'd0, g_dv}, 32'd0);
        chk("to_fd", fetched_data, 32'h00A0_0113);

        // Bus error response
        slv_err_en = 1'b1;
        do_req(LOAD_DATA, LW, 32'h0, 32'h44, 32'h0, g_ack, g_cyc, g_done, g_err, g_dv, g_sel, g_dato, g_we, g_adr);
        chk("berr_cyccnt", g_cyc, 32'd1);
        chk("berr_err", {31'd0, g_err}, 32'd1);
        chk("berr_dv", {31'd0, g_dv}, 32'd0);
        slv_err_en = 1'b0;

        // Reset in the middle of a bus cycle
        @(negedge clk);
        memory_operation = LOAD_DATA; funct3 = LW; addr = 32'h80; cyc = 1'b1;
        @(negedge clk);
        cyc = 1'b0; memory_operation = MEM_NONE;
        chk("rbus_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rbus_cyc_after", {31'd0, wb_cyc_o}, 32'd0);
        chk("rbus_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rbus_done_err2", {30'd0, done, err}, 32'd0);
        chk("rbus_fd", fetched_data, 32'd0);

        slv_ack_en = 1'b1;
        slv_data = 32'h0000_0013;
        do_req(FETCH_DATA, 3'd0, 32'h10, 32'h0, 32'h0, g_ack, g_cyc, g_done, g_err, g_dv, g_sel, g_dato, g_we, g_adr);
        chk("post_rst_done", {31'd0, g_done}, 32'd1);
        chk("post_rst_dv", {30'd0, g_dv, g_err}, 32'd2);
        chk("post_rst_adr", g_adr, 32'h10);
        chk("post_rst_fd", fetched_data, 32'h0000_0013);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
